mem_wb_buffer: RTL and testbench

MEM_WB_BUFFER -- requirements
Module: mem_wb_buffer

---
 rtl/mem_wb_buffer.sv | 179 +++++++++++++++++
 tb/tb_mem_wb_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_buffer.sv
// mem_wb_buffer: MEM/WB pipeline register with data-memory handshake.
//   Holds the pipeline (stall) while a load/store waits for dmem_resp, and
//   extracts and extends load data. It registers one writeback record per
//   retired instruction and flags misaligned accesses and memory wait timeouts.
// Ports:
//   clk, rst (async active-low)
//   mem_valid, mem_read, mem_write, funct3, addr_lsb   - MEM-stage access info
//   rd, rd_we, wb_sel, alu_out, u_imm, pc_plus4        - writeback request
//   dmem_rdata, dmem_resp                              - data-memory response
//   stall                                              - combinational upstream hold
//   wb_valid, regf_we, regf_rd, regf_wdata             - registered writeback
//   misalign, timeout                                  - registered error flags
module mem_wb_buffer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lsb,
  input  logic [4:0]  rd,
  input  logic        rd_we,
  input  logic [1:0]  wb_sel,
  input  logic [31:0] alu_out,
  input  logic [31:0] u_imm,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        wb_valid,
  output logic        regf_we,
  output logic [4:0]  regf_rd,
  output logic [31:0] regf_wdata,
  output logic        misalign,
  output logic        timeout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_r;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  cnt_inc_s;
  logic        pending_s;
  logic        done_s;
  logic        retire_s;
  logic        misalign_s;
  logic        we_s;
  logic [31:0] load_data_s;
  logic [31:0] wdata_s;

  // Select and extend the addressed byte/halfword; undefined funct3 yields 0.
  function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lsb);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = rdata[{lsb, 3'b000} +: 8];
    half_v = lsb[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b010:  res_v = rdata;
      3'b100:  res_v = {24'h000000, byte_v};
      3'b101:  res_v = {16'h0000, half_v};
      default: res_v = 32'h0000_0000;
    endcase
    return res_v;
  endfunction

  // Halfword needs even address, word needs 4-byte alignment; undefined load
  // encodings are reported through the same flag.
  function automatic logic check_misalign(input logic       is_load,
                                          input logic [2:0] f3,
                                          input logic [1:0] lsb);
    logic bad_v;
    case (f3[1:0])
      2'b01:   bad_v = lsb[0];
      2'b10:   bad_v = (lsb != 2'b00);
      default: bad_v = 1'b0;
    endcase
    if (is_load && ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111))) begin
      bad_v = 1'b1;
    end
    return bad_v;
  endfunction

  assign pending_s = mem_valid & (mem_read | mem_write);
  // Stall depends only on inputs so it remains meaningful while in reset.
  assign stall     = pending_s & ~dmem_resp;
  assign done_s    = pending_s & dmem_resp;
  assign retire_s  = mem_valid & ~stall;
  assign cnt_inc_s = (wait_cnt_r == 8'hFF) ? 8'hFF : (wait_cnt_r + 8'd1);

  // Misalign detection, register write qualification and writeback mux.
  always_comb begin
    load_data_s = extract_load(dmem_rdata, funct3, addr_lsb);
    if (pending_s) begin
      misalign_s = check_misalign(mem_read, funct3, addr_lsb);
    end else begin
      misalign_s = 1'b0;
    end
    we_s = rd_we & (rd != 5'd0) & ~mem_write & ~misalign_s;
    case (wb_sel)
      2'b00:   wdata_s = alu_out;
      2'b01:   wdata_s = load_data_s;
      2'b10:   wdata_s = u_imm;
      2'b11:   wdata_s = pc_plus4;
      default: wdata_s = 32'h0000_0000;
    endcase
  end

  // Handshake state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= 8'd0;
      timeout    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wait_cnt_r <= 8'd0;
          if (stall) begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (done_s) begin
            state_r    <= IDLE;
            wait_cnt_r <= 8'd0;
          end else if (!dmem_resp) begin
            wait_cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r    <= IDLE;
          wait_cnt_r <= 8'd0;
        end
      endcase
      // timeout tracks the incremented count so it rises with the counter.
      if (done_s) begin
        timeout <= 1'b0;
      end else if ((state_r == WAIT) && !dmem_resp && (cnt_inc_s >= TIMEOUT_C)) begin
        timeout <= 1'b1;
      end
    end
  end

  // Writeback register: loaded every cycle, bubble unless an instruction retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid   <= 1'b0;
      regf_we    <= 1'b0;
      regf_rd    <= 5'd0;
      regf_wdata <= 32'h0000_0000;
      misalign   <= 1'b0;
    end else if (retire_s) begin
      wb_valid   <= 1'b1;
      regf_we    <= we_s;
      regf_rd    <= rd;
      regf_wdata <= wdata_s;
      misalign   <= misalign_s;
    end else begin
      wb_valid   <= 1'b0;
      regf_we    <= 1'b0;
      regf_rd    <= 5'd0;
      regf_wdata <= 32'h0000_0000;
      misalign   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wb_buffer.sv
// Directed bench for mem_wb_buffer (TIMEOUT=4): a table of zero-wait
// single-cycle vectors plus hand-written multi-cycle sequences for wait
// states, timeout and reset.
module tb_mem_wb_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [1:0]  addr_lsb = 2'b00;
  logic [4:0]  rd = 5'd0;
  logic        rd_we = 1'b0;
  logic [1:0]  wb_sel = 2'b00;
  logic [31:0] alu_out = 32'h1111_1111;
  logic [31:0] u_imm = 32'hABCD_E000;
  logic [31:0] pc_plus4 = 32'h0000_0104;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_resp = 1'b0;
  logic        stall, wb_valid, regf_we, misalign, timeout;
  logic [4:0]  regf_rd;
  logic [31:0] regf_wdata;

  int passes = 0;
  int checks = 0;

  mem_wb_buffer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr_lsb(addr_lsb), .rd(rd),
    .rd_we(rd_we), .wb_sel(wb_sel), .alu_out(alu_out), .u_imm(u_imm),
    .pc_plus4(pc_plus4), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .stall(stall), .wb_valid(wb_valid), .regf_we(regf_we), .regf_rd(regf_rd),
    .regf_wdata(regf_wdata), .misalign(misalign), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mv, rdq, wrq;
    logic [2:0]  f3;
    logic [1:0]  lsb;
    logic [4:0]  rdx;
    logic        rdwe;
    logic [1:0]  sel;
    logic [31:0] rdata;
    logic        resp;
    logic        e_stall, e_valid, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t vecs[18];

  // {wb_valid, regf_we, regf_rd, regf_wdata, misalign, timeout}
  function automatic logic [40:0] obs();
    return {wb_valid, regf_we, regf_rd, regf_wdata, misalign, timeout};
  endfunction

  function automatic logic [40:0] expv(input logic v, input logic we, input logic [4:0] r,
                                      input logic [31:0] d, input logic m, input logic t);
    return {v, we, r, d, m, t};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_acc(input logic mv, input logic rdq, input logic wrq, input logic [2:0] f3,
                         input logic [1:0] lsb, input logic [4:0] r, input logic rw,
                         input logic [1:0] sel, input logic [31:0] rdata, input logic resp);
    mem_valid = mv; mem_read = rdq; mem_write = wrq; funct3 = f3; addr_lsb = lsb;
    rd = r; rd_we = rw; wb_sel = sel; dmem_rdata = rdata; dmem_resp = resp;
  endtask

  initial begin
    vecs[0]  = '{1'b1,1'b1,1'b0,3'b000,2'b11,5'd5, 1'b1,2'b01,32'h80112233,1'b1, 1'b0,1'b1,1'b1,5'd5, 32'hFFFFFF80,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,3'b100,2'b00,5'd6, 1'b1,2'b01,32'h80112233,1'b1, 1'b0,1'b1,1'b1,5'd6, 32'h00000033,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b0,3'b001,2'b10,5'd7, 1'b1,2'b01,32'h80112233,1'b1, 1'b0,1'b1,1'b1,5'd7, 32'hFFFF8011,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,3'b101,2'b00,5'd8, 1'b1,2'b01,32'hBEEF8000,1'b1, 1'b0,1'b1,1'b1,5'd8, 32'h00008000,1'b0};
    vecs[4]  = '{1'b1,1'b1,1'b0,3'b010,2'b00,5'd9, 1'b1,2'b01,32'hDEADBEEF,1'b1, 1'b0,1'b1,1'b1,5'd9, 32'hDEADBEEF,1'b0};
    vecs[5]  = '{1'b1,1'b1,1'b0,3'b010,2'b01,5'd10,1'b1,2'b01,32'hCAFEF00D,1'b1, 1'b0,1'b1,1'b0,5'd10,32'hCAFEF00D,1'b1};
    vecs[6]  = '{1'b1,1'b1,1'b0,3'b001,2'b00,5'd0, 1'b1,2'b01,32'h00001234,1'b1, 1'b0,1'b1,1'b0,5'd0, 32'h00001234,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b0,3'b000,2'b00,5'd3, 1'b1,2'b00,32'hFFFFFFFF,1'b0, 1'b0,1'b1,1'b1,5'd3, 32'h11111111,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0,3'b000,2'b00,5'd4, 1'b1,2'b10,32'h00000000,1'b0, 1'b0,1'b1,1'b1,5'd4, 32'hABCDE000,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,3'b000,2'b00,5'd31,1'b1,2'b11,32'h00000000,1'b0, 1'b0,1'b1,1'b1,5'd31,32'h00000104,1'b0};
    vecs[10] = '{1'b1,1'b0,1'b1,3'b010,2'b00,5'd2, 1'b1,2'b00,32'h00000000,1'b1, 1'b0,1'b1,1'b0,5'd2, 32'h11111111,1'b0};
    vecs[11] = '{1'b1,1'b0,1'b1,3'b001,2'b01,5'd2, 1'b1,2'b00,32'h00000000,1'b1, 1'b0,1'b1,1'b0,5'd2, 32'h11111111,1'b1};
    vecs[12] = '{1'b1,1'b1,1'b0,3'b011,2'b00,5'd14,1'b1,2'b01,32'h12345678,1'b1, 1'b0,1'b1,1'b0,5'd14,32'h00000000,1'b1};
    vecs[13] = '{1'b0,1'b1,1'b0,3'b010,2'b00,5'd15,1'b1,2'b01,32'h12345678,1'b1, 1'b0,1'b0,1'b0,5'd0, 32'h00000000,1'b0};
    vecs[14] = '{1'b1,1'b0,1'b0,3'b000,2'b00,5'd12,1'b0,2'b00,32'h00000000,1'b0, 1'b0,1'b1,1'b0,5'd12,32'h11111111,1'b0};
    vecs[15] = '{1'b1,1'b1,1'b0,3'b000,2'b01,5'd16,1'b1,2'b01,32'h80112233,1'b1, 1'b0,1'b1,1'b1,5'd16,32'h00000022,1'b0};
    vecs[16] = '{1'b1,1'b1,1'b0,3'b101,2'b01,5'd17,1'b1,2'b01,32'h80112233,1'b1, 1'b0,1'b1,1'b0,5'd17,32'h00002233,1'b1};
    vecs[17] = '{1'b1,1'b0,1'b1,3'b000,2'b11,5'd18,1'b1,2'b00,32'h00000000,1'b1, 1'b0,1'b1,1'b0,5'd18,32'h11111111,1'b0};

    // Reset state
    #1 rst = 1'b0;
    #1 chk("reset_outputs", 64'(obs()), 64'(expv(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0)));
    chk("reset_stall", 64'(stall), 64'd0);
    step();
    #2 rst = 1'b1;

    // Table of single-cycle vectors
    for (int i = 0; i < 18; i++) begin
      set_acc(vecs[i].mv, vecs[i].rdq, vecs[i].wrq, vecs[i].f3, vecs[i].lsb, vecs[i].rdx,
              vecs[i].rdwe, vecs[i].sel, vecs[i].rdata, vecs[i].resp);
      #1 chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
      step();
      chk($sformatf("vec%0d_out", i), 64'(obs()),
          64'(expv(vecs[i].e_valid, vecs[i].e_we, vecs[i].e_rd, vecs[i].e_data, vecs[i].e_mis, 1'b0)));
    end

    // lhu with three wait cycles
    set_acc(1'b1, 1'b1, 1'b0, 3'b101, 2'b10, 5'd11, 1'b1, 2'b01, 32'hFFFFFFFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("wait%0d_stall", i), 64'(stall), 64'd1);
      step();
      chk($sformatf("wait%0d_bubble", i), 64'(obs()), 64'(expv(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0)));
    end
    dmem_rdata = 32'hBEEF0000; dmem_resp = 1'b1;
    #1 chk("wait_resp_stall", 64'(stall), 64'd0);
    step();
    chk("wait_retire", 64'(obs()), 64'(expv(1'b1, 1'b1, 5'd11, 32'h0000BEEF, 1'b0, 1'b0)));

    // Timeout: six cycles without response, then response
    set_acc(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 5'd13, 1'b1, 2'b01, 32'h01020304, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("to%0d_stall", i), 64'(stall), 64'd1);
      step();
      chk($sformatf("to%0d_out", i), 64'(obs()),
          64'(expv(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, (i >= 4) ? 1'b1 : 1'b0)));
    end
    dmem_resp = 1'b1;
    step();
    chk("to_retire", 64'(obs()), 64'(expv(1'b1, 1'b1, 5'd13, 32'h01020304, 1'b0, 1'b0)));

    // Async reset clears a live writeback immediately
    set_acc(1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 5'd3, 1'b1, 2'b00, 32'h0, 1'b0);
    step();
    chk("pre_rst_out", 64'(obs()), 64'(expv(1'b1, 1'b1, 5'd3, 32'h11111111, 1'b0, 1'b0)));
    mem_valid = 1'b0;
    #2 rst = 1'b0;
    #1 chk("rst_async_clear", 64'(obs()), 64'(expv(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0)));
    #2 rst = 1'b1;

    // Reset in the middle of a timed-out wait
    set_acc(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 5'd20, 1'b1, 2'b01, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("mid_wait_timeout", 64'(timeout), 64'd1);
    #2 rst = 1'b0;
    #1 chk("mid_wait_rst_out", 64'(obs()), 64'(expv(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0)));
    chk("mid_wait_rst_stall", 64'(stall), 64'd1);
    mem_valid = 1'b0;
    #2 rst = 1'b1;
    step();
    chk("post_rst_no_retire", 64'(obs()), 64'(expv(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0)));
    set_acc(1'b1, 1'b1, 1'b0, 3'b010, 2'b00, 5'd21, 1'b1, 2'b01, 32'h0A0B0C0D, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst_wait%0d", i), 64'(obs()), 64'(expv(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0)));
    end
    dmem_resp = 1'b1;
    step();
    chk("post_rst_retire", 64'(obs()), 64'(expv(1'b1, 1'b1, 5'd21, 32'h0A0B0C0D, 1'b0, 1'b0)));
    u_imm = 32'h12345000;
    set_acc(1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 5'd22, 1'b1, 2'b10, 32'h0, 1'b0);
    step();
    chk("post_rst_uimm", 64'(obs()), 64'(expv(1'b1, 1'b1, 5'd22, 32'h12345000, 1'b0, 1'b0)));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
